// File: rtl/uart_debug_pkg.sv
// rtl/uart_debug_pkg.sv - shared states, ASCII constants and hex helpers for the UART debug monitor
`timescale 1ns/1ps
package uart_debug_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_EOL,
        S_SKIP,
        S_MEM,
        S_WAIT,
        S_REPLY
    } state_t;

    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_K    = 8'h4B;
    localparam logic [7:0] CH_QM   = 8'h3F;
    localparam logic [7:0] CH_T    = 8'h54;
    localparam logic [7:0] CH_R_UC = 8'h52;
    localparam logic [7:0] CH_R_LC = 8'h72;
    localparam logic [7:0] CH_W_UC = 8'h57;
    localparam logic [7:0] CH_W_LC = 8'h77;

    // Reply images are packed first-byte-lowest for the transmit queue.
    localparam logic [31:0] REPLY_OK  = {8'h00, CH_LF, CH_CR, CH_K};
    localparam logic [31:0] REPLY_ERR = {8'h00, CH_LF, CH_CR, CH_QM};
    localparam logic [31:0] REPLY_TMO = {8'h00, CH_LF, CH_CR, CH_T};

    // Bit 4 is the valid flag, bits 3:0 the decoded nibble.
    function automatic logic [4:0] hex2nib(input logic [7:0] ch);
        logic [4:0] r;
        r = 5'd0;
        if (ch >= 8'h30 && ch <= 8'h39)
            r = {1'b1, ch[3:0]};
        else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66))
            r = {1'b1, ch[3:0] + 4'd9};
        return r;
    endfunction

    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        logic [7:0] r;
        r = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
        return r;
    endfunction

endpackage

// File: rtl/uart_debug_txq.sv
// rtl/uart_debug_txq.sv - four-byte reply queue driving the transmitter strobe/busy handshake
`timescale 1ns/1ps
module uart_debug_txq
    import uart_debug_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        load,
    input  logic [2:0]  load_count,
    input  logic [31:0] load_bytes,
    input  logic        TX_BUSY,
    output logic [7:0]  TX_DATA,
    output logic        TX_STROBE,
    output logic        done
);

    logic [31:0] bytes_q;
    logic [2:0]  remaining;
    logic        cooldown;
    logic        active;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bytes_q   <= '0;
            remaining <= '0;
            cooldown  <= 1'b0;
            active    <= 1'b0;
            TX_DATA   <= '0;
            TX_STROBE <= 1'b0;
            done      <= 1'b0;
        end else begin
            TX_STROBE <= 1'b0;
            done      <= 1'b0;
            if (load) begin
                bytes_q   <= load_bytes;
                remaining <= load_count;
                cooldown  <= 1'b0;
                active    <= 1'b1;
            end else if (active) begin
                // TX_BUSY lags the strobe by a cycle, so skip one sample after each send.
                if (cooldown) begin
                    cooldown <= 1'b0;
                end else if (remaining == 3'd0) begin
                    done   <= 1'b1;
                    active <= 1'b0;
                end else if (!TX_BUSY) begin
                    TX_DATA   <= bytes_q[7:0];
                    TX_STROBE <= 1'b1;
                    bytes_q   <= {8'h00, bytes_q[31:8]};
                    remaining <= remaining - 3'd1;
                    cooldown  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_debug_monitor.sv
// rtl/uart_debug_monitor.sv - ASCII peek/poke command engine bridging the UART to a RAM request port
`timescale 1ns/1ps
module uart_debug_monitor
    import uart_debug_pkg::*;
#(
    parameter int ADDR_HEX  = 6,
    parameter int TIMEOUT   = 1_080_000,
    parameter int TIMEOUT_W = $clog2(TIMEOUT + 1)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [7:0]              RX_DATA,
    input  logic                    RX_VALID,
    output logic [7:0]              TX_DATA,
    output logic                    TX_STROBE,
    input  logic                    TX_BUSY,
    output logic [4*ADDR_HEX-1:0]   RAM_ADDR,
    output logic [7:0]              RAM_DIN,
    output logic                    RAM_OE_n,
    output logic                    RAM_WE_n,
    input  logic [7:0]              RAM_DOUT,
    input  logic                    RAM_ACK_n,
    output logic                    BUSY
);

    localparam int AW    = 4 * ADDR_HEX;
    localparam int CNT_W = $clog2(ADDR_HEX + 1);

    state_t               state;
    logic [AW-1:0]        addr_q;
    logic [7:0]           data_q;
    logic [CNT_W-1:0]     digit_cnt;
    logic                 is_write;
    logic [TIMEOUT_W-1:0] timer;

    logic                 q_load;
    logic [2:0]           q_count;
    logic [31:0]          q_bytes;
    logic                 q_done;

    logic [4:0]           rx_hex;
    logic                 rx_byte;
    logic                 rx_cr;

    assign rx_hex  = hex2nib(RX_DATA);
    assign rx_byte = RX_VALID && (RX_DATA != CH_LF);
    assign rx_cr   = (RX_DATA == CH_CR);
    assign BUSY    = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            digit_cnt <= '0;
            is_write  <= 1'b0;
            timer     <= '0;
            q_load    <= 1'b0;
            q_count   <= '0;
            q_bytes   <= '0;
            RAM_ADDR  <= '0;
            RAM_DIN   <= '0;
            RAM_OE_n  <= 1'b1;
            RAM_WE_n  <= 1'b1;
        end else begin
            q_load <= 1'b0;
            case (state)
                S_IDLE: if (rx_byte) begin
                    if (RX_DATA == CH_R_UC || RX_DATA == CH_R_LC) begin
                        is_write  <= 1'b0;
                        digit_cnt <= '0;
                        state     <= S_ADDR;
                    end else if (RX_DATA == CH_W_UC || RX_DATA == CH_W_LC) begin
                        is_write  <= 1'b1;
                        digit_cnt <= '0;
                        state     <= S_ADDR;
                    end else if (!rx_cr) begin
                        state <= S_SKIP;
                    end
                end
                S_ADDR: if (rx_byte) begin
                    if (rx_hex[4]) begin
                        addr_q    <= {addr_q[AW-5:0], rx_hex[3:0]};
                        digit_cnt <= digit_cnt + CNT_W'(1);
                        if (digit_cnt == CNT_W'(ADDR_HEX - 1)) begin
                            digit_cnt <= '0;
                            state     <= is_write ? S_DATA : S_EOL;
                        end
                    end else if (rx_cr) begin
                        q_load  <= 1'b1;
                        q_count <= 3'd3;
                        q_bytes <= REPLY_ERR;
                        state   <= S_REPLY;
                    end else begin
                        state <= S_SKIP;
                    end
                end
                S_DATA: if (rx_byte) begin
                    if (rx_hex[4]) begin
                        data_q    <= {data_q[3:0], rx_hex[3:0]};
                        digit_cnt <= digit_cnt + CNT_W'(1);
                        if (digit_cnt == CNT_W'(1))
                            state <= S_EOL;
                    end else if (rx_cr) begin
                        q_load  <= 1'b1;
                        q_count <= 3'd3;
                        q_bytes <= REPLY_ERR;
                        state   <= S_REPLY;
                    end else begin
                        state <= S_SKIP;
                    end
                end
                // Request goes out on the CR edge itself; MEM is the first cycle of the wait window.
                S_EOL: if (rx_byte) begin
                    if (rx_cr) begin
                        RAM_ADDR <= addr_q;
                        RAM_DIN  <= data_q;
                        RAM_OE_n <= is_write;
                        RAM_WE_n <= !is_write;
                        timer    <= TIMEOUT_W'(TIMEOUT);
                        state    <= S_MEM;
                    end else begin
                        state <= S_SKIP;
                    end
                end
                S_SKIP: if (rx_byte && rx_cr) begin
                    q_load  <= 1'b1;
                    q_count <= 3'd3;
                    q_bytes <= REPLY_ERR;
                    state   <= S_REPLY;
                end
                S_MEM, S_WAIT: begin
                    if (!RAM_ACK_n) begin
                        RAM_OE_n <= 1'b1;
                        RAM_WE_n <= 1'b1;
                        q_load   <= 1'b1;
                        if (is_write) begin
                            q_count <= 3'd3;
                            q_bytes <= REPLY_OK;
                        end else begin
                            q_count <= 3'd4;
                            q_bytes <= {CH_LF, CH_CR, nib2hex(RAM_DOUT[3:0]), nib2hex(RAM_DOUT[7:4])};
                        end
                        state <= S_REPLY;
                    end else if (timer == TIMEOUT_W'(1)) begin
                        RAM_OE_n <= 1'b1;
                        RAM_WE_n <= 1'b1;
                        q_load   <= 1'b1;
                        q_count  <= 3'd3;
                        q_bytes  <= REPLY_TMO;
                        state    <= S_REPLY;
                    end else begin
                        timer <= timer - TIMEOUT_W'(1);
                        state <= S_WAIT;
                    end
                end
                S_REPLY: if (q_done) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    uart_debug_txq u_txq (
        .CLK        (CLK),
        .RESET      (RESET),
        .load       (q_load),
        .load_count (q_count),
        .load_bytes (q_bytes),
        .TX_BUSY    (TX_BUSY),
        .TX_DATA    (TX_DATA),
        .TX_STROBE  (TX_STROBE),
        .done       (q_done)
    );

endmodule

// File: doc/uart_debug_monitor.md
Name: uart_debug_monitor

Overview:
- Debug command engine between the board UART byte receiver/transmitter and one RAM-style request port (an UMA secondary slot or a dedicated SDRAM client).
- Parses an ASCII peek/poke protocol from the host, performs single-byte SDRAM reads and writes, and returns ASCII replies.
- Replaces the tied-off UART RX/TX interface signals at the board top level.
- Runs entirely in the 108 MHz system clock domain.

Parameters:
- ADDR_HEX, 6, number of hex digits in an address; RAM_ADDR width = 4*ADDR_HEX bits.
- TIMEOUT, 1_080_000, clock cycles to wait for RAM_ACK before aborting (10 ms at 108 MHz).
- TIMEOUT_W, $clog2(TIMEOUT+1), width of the timeout counter.

Ports:
- CLK  in  1  system clock (108 MHz).
- RESET  in  1  synchronous reset, active-high.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  one-cycle strobe; RX_DATA is valid this cycle.
- TX_DATA  out  8  byte to transmit.
- TX_STROBE  out  1  one-cycle request to send TX_DATA.
- TX_BUSY  in  1  high while the transmitter is shifting.
- RAM_ADDR  out  4*ADDR_HEX  byte address.
- RAM_DIN  out  8  write data.
- RAM_OE_n  out  1  read request, active-low.
- RAM_WE_n  out  1  write request, active-low.
- RAM_DOUT  in  8  read data; valid in the RAM_ACK_n low cycle.
- RAM_ACK_n  in  1  one-cycle completion strobe, active-low.
- BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is synchronous and active-high: one clock, with RESET sampled on the CLK rising edge. State, counters and registers clear.
- Reset values of outputs:
  - TX_STROBE = 0, TX_DATA = 0.
  - RAM_OE_n = 1, RAM_WE_n = 1, RAM_ADDR = 0, RAM_DIN = 0.
  - BUSY = 0.
- Command syntax:
  - Read: 'R' + ADDR_HEX hex digits + CR.
  - Write: 'W' + ADDR_HEX hex digits + 2 hex digits + CR.
  - Command letter and hex digits are case-insensitive. LF is ignored in every receive state.
- Replies:
  - Read: 2 uppercase hex digits, CR, LF.
  - Write: 'K', CR, LF.
  - Syntax error: '?', CR, LF.
  - RAM timeout: 'T', CR, LF.
- FSM states:
  - IDLE: 'R' or 'W' → ADDR with the digit counter cleared. CR → no action. Any other character → SKIP.
  - ADDR: each hex digit shifts left 4 into the address register. After ADDR_HEX digits → DATA (write) or EOL (read). A non-hex character → SKIP; CR → ERR.
  - DATA: collects 2 digits into the data register → EOL. Same error rules as ADDR.
  - EOL: CR → MEM. Anything else → SKIP.
  - SKIP: discard bytes until CR → ERR.
  - MEM: drive RAM_ADDR, RAM_DIN and RAM_OE_n or RAM_WE_n low. Load the timeout counter → WAIT.
  - WAIT: hold the request until RAM_ACK_n is low. On ack, deassert the request the next cycle, latch RAM_DOUT for a read, then go to the reply sequence. If the counter reaches 0 first, deassert the request and reply 'T'.
  - REPLY: emits a queued sequence of up to 4 bytes, then returns to IDLE.
- Transmit rule: a byte is issued by pulsing TX_STROBE for exactly 1 cycle while TX_BUSY = 0. After the pulse, wait one cycle before sampling TX_BUSY again, to cover the transmitter's busy-latency.
- RX_VALID during MEM, WAIT or REPLY: the byte is dropped, with no error reply.
- Hex decode: '0'–'9', 'A'–'F', 'a'–'f'. Encode uses uppercase.
- RAM_ACK_n arriving in the same cycle as the timeout expiry: the ack wins.
- RESET during WAIT: the request deasserts on the next edge, and a late RAM_ACK_n afterwards is ignored in IDLE.
- Latency: a read request is asserted 1 cycle after the RX_VALID carrying CR.

Decomposition:
- Package uart_debug_pkg:
  - state enum.
  - ASCII constants (CR = 8'h0D, LF = 8'h0A, 'K', '?', 'T').
  - functions hex2nib (returns valid flag + nibble) and nib2hex.
- One sub-module, uart_debug_txq:
  - 4-entry byte queue with load-all interface: count plus 4 bytes.
  - Owns the TX_STROBE/TX_BUSY handshake.
  - Returns a done pulse when the queue empties.

Test Plan:
- "R00012A\r" with RAM_DOUT = 8'h5C acked after 3 cycles → exactly one RAM_OE_n low window with RAM_ADDR = 24'h00012A; TX sequence "5C\r\n"; BUSY returns to 0.
- "w0000ffa5\r" → exactly one RAM_WE_n low window with RAM_ADDR = 24'h0000FF and RAM_DIN = 8'hA5; TX sequence "K\r\n".
- "R00G000\r" → no RAM request; TX "?\r\n". Also "R12\r" → "?\r\n".
- "R000000\r" with RAM_ACK_n held high → request held for TIMEOUT cycles (bench uses TIMEOUT = 50), then deasserted; TX "T\r\n".
- TX_BUSY held high for 20 cycles after each strobe, and extra RX bytes injected during the reply → each TX_STROBE only while TX_BUSY = 0, no byte lost or duplicated, injected bytes ignored.
- RESET asserted for 1 cycle in WAIT → RAM_OE_n = 1 next cycle, no TX; a following "R000001\r" works normally.
